ram_cmd_ctrl: RTL and testbench
===============================

Name: ram_cmd_ctrl

Overview:
Command sequencer directly upstream of the single-port RAM. Accepts read/write commands over a valid/ready interface and drives the RAM's en/wr_rd/addr/data_in pins. Captures read data on the RAM's out_en pulse and returns it over a valid/ready response channel. Detects missing read returns with a timeout and keeps read/write statistics counters.

Parameters:
DATA_WIDTH, 8, data word width; matches the RAM data width
ADDR_WIDTH, 4, address width; RAM depth is 2**ADDR_WIDTH
TIMEOUT, 8, cycles to wait for ram_out_en after a read issue before flagging an error (must be 2 or more)

Ports:
clk  in  1  single clock, rising edge
rstn  in  1  synchronous active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  controller can take a command this cycle
cmd_wr  in  1  1 = write, 0 = read
cmd_addr  in  ADDR_WIDTH  command address
cmd_wdata  in  DATA_WIDTH  write data
rsp_valid  out  1  read response present
rsp_ready  in  1  consumer takes the response
rsp_data  out  DATA_WIDTH  read data (0 on error)
rsp_err  out  1  response is a timeout error
ram_en  out  1  to RAM en
ram_wr_rd  out  1  to RAM wr_rd
ram_addr  out  ADDR_WIDTH  to RAM addr
ram_wdata  out  DATA_WIDTH  to RAM data_in
ram_rdata  in  DATA_WIDTH  from RAM data_out
ram_out_en  in  1  from RAM out_en
wr_cnt  out  16  completed writes, wraps at 0xFFFF to 0
rd_cnt  out  16  completed reads (including errors), wraps

Behaviour:
- All outputs are registered.
- Reset values:
  - ram_en=1, ram_wr_rd=1, ram_addr=0, ram_wdata=0. en is held high so the RAM's synchronous reset clear takes effect.
  - The first cycle after reset writes 0 to address 0, which is harmless.
  - cmd_ready=0, rsp_valid=0, rsp_err=0, rsp_data=0, wr_cnt=0, rd_cnt=0, state=IDLE (or INIT, see Optional Feature).
- States: IDLE, WRITE, RD_ISSUE, RD_WAIT, RESP, GAP.
- IDLE:
  - cmd_ready=1 and ram_en=0.
  - On cmd_valid&&cmd_ready, latch wr/addr/wdata. Go to WRITE if wr, otherwise RD_ISSUE.
- WRITE:
  - Exactly one cycle with ram_en=1, ram_wr_rd=1, latched addr and data.
  - wr_cnt++. Next state is IDLE.
  - Back-to-back writes sustain one write every 2 cycles.
- RD_ISSUE:
  - One cycle with ram_en=1, ram_wr_rd=0, latched addr. Then go to RD_WAIT with ram_en=0 and the timeout counter cleared.
- RD_WAIT:
  - If ram_out_en=1: capture ram_rdata into rsp_data, rsp_err=0, go to RESP.
  - Otherwise increment the counter. On reaching TIMEOUT: rsp_data=0, rsp_err=1, go to RESP.
  - Nominal read latency is 3 cycles from command accept to rsp_valid.
- RESP:
  - rsp_valid=1. rsp_data and rsp_err are held stable until rsp_ready=1.
  - On the handshake: rd_cnt++, rsp_valid=0, go to GAP.
- GAP:
  - One idle cycle with ram_en=0 and cmd_ready=0. This guarantees the RAM's out_en pulse and read stall have ended before the next command.
  - Next state is IDLE.
- cmd_ready is 0 in every state except IDLE. Only one command is outstanding at a time.
- ram_out_en seen outside RD_WAIT is ignored.
- A command presented while cmd_ready=0 is not consumed. The source must hold it.
- Reset asserted mid-operation: abort immediately, drop any pending response, return all outputs to reset values. Counters clear.

Optional Feature:
Macro RAM_CMD_CTRL_INIT_EN.
- Defined:
  - Reset enters state INIT instead of IDLE.
  - INIT writes 0 to addresses 0 through 2**ADDR_WIDTH-1, one write every cycle with ram_en=1 and ram_wr_rd=1, then goes to IDLE.
  - cmd_ready=0 throughout INIT. Init writes do not count in wr_cnt.
  - The sweep takes 2**ADDR_WIDTH cycles (16 by default).
- Undefined: no INIT state. IDLE is reached directly after reset.

Test Plan:
1. Reset held 3 cycles then released -> ram_en=1 during reset; cmd_ready=1 on the first post-reset IDLE cycle; counters 0.
2. Write addr 5 = 0xA5, then read addr 5 -> RAM sees one en/wr_rd=1 cycle; rsp_valid 3 cycles after read accept with rsp_data=0xA5, rsp_err=0; wr_cnt=1, rd_cnt=1.
3. Read addr 5 with rsp_ready held 0 for 4 cycles -> rsp_valid and rsp_data=0xA5 stay stable; no new cmd_ready until the handshake plus GAP.
4. Read with ram_out_en forced 0 -> after 8 cycles in RD_WAIT, rsp_valid=1, rsp_err=1, rsp_data=0; rd_cnt increments.
5. Reset asserted during RD_WAIT -> rsp_valid never asserts; state returns to IDLE; counters 0.
6. With RAM_CMD_CTRL_INIT_EN, preload RAM, reset, then read addr 15 -> cmd_ready low for 16 cycles after reset; rsp_data=0x00.

Source files
------------

// File: rtl/ram_cmd_ctrl.sv
// ---------------------------------------------------------------------------
// ram_cmd_ctrl
//
// Command sequencer in front of a single-port RAM. Read/write commands arrive
// over a valid/ready channel, one at a time, and are turned into RAM pin
// activity (en / wr_rd / addr / data_in). Read data is captured on the RAM's
// out_en pulse and returned over a valid/ready response channel. A read whose
// out_en never arrives is completed as an error response after TIMEOUT cycles.
// Completed writes and reads are counted in free-running 16-bit counters.
//
// Every output is a register. The FSM is written as a state register, a
// next-state process and an output process; the output process computes the
// value each output register takes on the next edge from the next state.
//
// Optional feature (compile-time macro RAM_CMD_CTRL_INIT_EN):
//   When defined, reset enters an INIT state that writes zero to every RAM
//   address, one per cycle, before the controller accepts commands. Init
//   writes are not counted in wr_cnt. When undefined, reset goes straight to
//   IDLE.
//
// Parameters:
//   DATA_WIDTH  RAM data word width
//   ADDR_WIDTH  RAM address width (depth 2**ADDR_WIDTH)
//   TIMEOUT     cycles waited for ram_out_en after a read issue (>= 2)
//
// Ports:
//   clk, rstn                clock (rising edge), synchronous active-low reset
//   cmd_valid / cmd_ready    command handshake
//   cmd_wr, cmd_addr,        command: 1 = write, 0 = read; address; write data
//   cmd_wdata
//   rsp_valid / rsp_ready    read-response handshake
//   rsp_data, rsp_err        read data (0 on error); timeout error flag
//   ram_en, ram_wr_rd,       RAM control / address / write-data pins
//   ram_addr, ram_wdata
//   ram_rdata, ram_out_en    RAM read data and its valid pulse
//   wr_cnt, rd_cnt           completed writes / completed reads (incl. errors)
// ---------------------------------------------------------------------------
module ram_cmd_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int TIMEOUT    = 8
) (
    input  logic                  clk,
    input  logic                  rstn,

    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_wr,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,

    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  rsp_err,

    output logic                  ram_en,
    output logic                  ram_wr_rd,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    input  logic [DATA_WIDTH-1:0] ram_rdata,
    input  logic                  ram_out_en,

    output logic [15:0]           wr_cnt,
    output logic [15:0]           rd_cnt
);

    // Timeout counter only has to reach TIMEOUT-1: the transition to RESP is
    // taken in the cycle the counter holds that value, giving TIMEOUT cycles
    // in RD_WAIT in total.
    localparam int              TW     = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0]   T_LAST = TW'(TIMEOUT - 1);

`ifdef RAM_CMD_CTRL_INIT_EN
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WRITE    = 3'd1,
        RD_ISSUE = 3'd2,
        RD_WAIT  = 3'd3,
        RESP     = 3'd4,
        GAP      = 3'd5,
        INIT     = 3'd6
    } state_t;
    localparam state_t RESET_STATE = INIT;
`else
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WRITE    = 3'd1,
        RD_ISSUE = 3'd2,
        RD_WAIT  = 3'd3,
        RESP     = 3'd4,
        GAP      = 3'd5
    } state_t;
    localparam state_t RESET_STATE = IDLE;
`endif

    state_t                  state;
    state_t                  next_state;
    logic [TW-1:0]           tcnt;

    logic                    cmd_ready_nxt;
    logic                    rsp_valid_nxt;
    logic [DATA_WIDTH-1:0]   rsp_data_nxt;
    logic                    rsp_err_nxt;
    logic                    ram_en_nxt;
    logic                    ram_wr_rd_nxt;
    logic [ADDR_WIDTH-1:0]   ram_addr_nxt;
    logic [DATA_WIDTH-1:0]   ram_wdata_nxt;

    logic                    cmd_fire;
    logic                    rsp_fire;

    // Statistics counters wrap naturally at 0xFFFF.
    function automatic logic [15:0] wrap_inc(input logic [15:0] v);
        return v + 16'd1;
    endfunction

    // cmd_ready / rsp_valid are registered, so the handshakes use the
    // registered copies the outside world actually sees.
    assign cmd_fire = cmd_valid && cmd_ready;
    assign rsp_fire = rsp_valid && rsp_ready && (state == RESP);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state <= RESET_STATE;
        end else begin
            state <= next_state;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (cmd_fire) begin
                    next_state = cmd_wr ? WRITE : RD_ISSUE;
                end
            end
            WRITE:    next_state = IDLE;
            RD_ISSUE: next_state = RD_WAIT;
            RD_WAIT: begin
                if (ram_out_en || (tcnt == T_LAST)) begin
                    next_state = RESP;
                end
            end
            RESP: begin
                if (rsp_fire) begin
                    next_state = GAP;
                end
            end
            GAP:      next_state = IDLE;
`ifdef RAM_CMD_CTRL_INIT_EN
            INIT: begin
                // ram_addr already shows the address being swept this cycle.
                if (ram_addr == {ADDR_WIDTH{1'b1}}) begin
                    next_state = IDLE;
                end
            end
`endif
            default:  next_state = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic: value every output register takes on the next edge.
    // The RAM address/data registers double as the command latch, since the
    // command is captured on the same edge that enters WRITE / RD_ISSUE.
    // ------------------------------------------------------------------
    always_comb begin
        cmd_ready_nxt = 1'b0;
        rsp_valid_nxt = 1'b0;
        rsp_data_nxt  = rsp_data;
        rsp_err_nxt   = rsp_err;
        ram_en_nxt    = 1'b0;
        ram_wr_rd_nxt = ram_wr_rd;
        ram_addr_nxt  = ram_addr;
        ram_wdata_nxt = ram_wdata;

        case (next_state)
            IDLE: begin
                cmd_ready_nxt = 1'b1;
            end
            WRITE: begin
                ram_en_nxt    = 1'b1;
                ram_wr_rd_nxt = 1'b1;
                ram_addr_nxt  = cmd_addr;
                ram_wdata_nxt = cmd_wdata;
            end
            RD_ISSUE: begin
                ram_en_nxt    = 1'b1;
                ram_wr_rd_nxt = 1'b0;
                ram_addr_nxt  = cmd_addr;
            end
            RESP: begin
                rsp_valid_nxt = 1'b1;
                // Capture only on entry; while waiting for rsp_ready the
                // response is held.
                if (state == RD_WAIT) begin
                    rsp_data_nxt = ram_out_en ? ram_rdata : '0;
                    rsp_err_nxt  = !ram_out_en;
                end
            end
`ifdef RAM_CMD_CTRL_INIT_EN
            INIT: begin
                ram_en_nxt    = 1'b1;
                ram_wr_rd_nxt = 1'b1;
                ram_addr_nxt  = ram_addr + ADDR_WIDTH'(1);
                ram_wdata_nxt = '0;
            end
`endif
            default: begin
                // RD_WAIT and GAP: RAM idle, no handshake offered.
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output registers. Reset keeps ram_en high with a write of 0 to
    // address 0 so the RAM's own synchronous reset clear is enabled.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rstn) begin
            cmd_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
            ram_en    <= 1'b1;
            ram_wr_rd <= 1'b1;
            ram_addr  <= '0;
            ram_wdata <= '0;
        end else begin
            cmd_ready <= cmd_ready_nxt;
            rsp_valid <= rsp_valid_nxt;
            rsp_data  <= rsp_data_nxt;
            rsp_err   <= rsp_err_nxt;
            ram_en    <= ram_en_nxt;
            ram_wr_rd <= ram_wr_rd_nxt;
            ram_addr  <= ram_addr_nxt;
            ram_wdata <= ram_wdata_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Read-return timeout counter: zero outside RD_WAIT, so it starts from
    // zero on every entry.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rstn || (state != RD_WAIT)) begin
            tcnt <= '0;
        end else begin
            tcnt <= tcnt + TW'(1);
        end
    end

    // ------------------------------------------------------------------
    // Statistics. A write completes in its single WRITE cycle; a read
    // (good or timed out) completes on the response handshake.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_cnt <= '0;
            rd_cnt <= '0;
        end else begin
            if (state == WRITE) begin
                wr_cnt <= wrap_inc(wr_cnt);
            end
            if (rsp_fire) begin
                rd_cnt <= wrap_inc(rd_cnt);
            end
        end
    end

endmodule

// File: tb/tb_ram_cmd_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ram_cmd_ctrl
//
// Self-checking bench for ram_cmd_ctrl. A small behavioural single-port RAM
// (one-cycle registered read with an out_en pulse, which can be suppressed)
// sits on the RAM pins. Expected results come from a reference model kept at
// transaction level: an array of expected memory contents, expected counter
// values, and read latency derived from the accept -> issue -> wait -> resp
// sequence. Build with +define+RAM_CMD_CTRL_INIT_EN to exercise the INIT
// sweep; the reference model follows the same macro.
// ---------------------------------------------------------------------------
module tb_ram_cmd_ctrl;

    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int TO    = 8;
    localparam int DEPTH = 1 << AW;
`ifdef RAM_CMD_CTRL_INIT_EN
    localparam int READY_WAIT = DEPTH;
`else
    localparam int READY_WAIT = 1;
`endif

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_wr = 1'b0;
    logic [AW-1:0] cmd_addr = '0;
    logic [DW-1:0] cmd_wdata = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [DW-1:0] rsp_data;
    logic          rsp_err;
    logic          ram_en;
    logic          ram_wr_rd;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata;
    logic          ram_out_en;
    logic [15:0]   wr_cnt;
    logic [15:0]   rd_cnt;

    logic          kill_out_en = 1'b0;
    logic [DW-1:0] ram_mem [DEPTH];
    int            ram_wr_seen;

    // Reference model state
    logic [DW-1:0] ref_mem [DEPTH];
    int            exp_wr;
    int            exp_rd;

    int total = 0;
    int bad   = 0;

    ram_cmd_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT(TO)) dut (
        .clk(clk), .rstn(rstn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_err(rsp_err),
        .ram_en(ram_en), .ram_wr_rd(ram_wr_rd), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .ram_out_en(ram_out_en),
        .wr_cnt(wr_cnt), .rd_cnt(rd_cnt)
    );

    always #5 clk = ~clk;

    // Behavioural RAM: write on en&wr_rd; read registers data and pulses
    // out_en for one cycle after an en&!wr_rd cycle.
    initial begin
        ram_out_en  = 1'b0;
        ram_rdata   = '0;
        ram_wr_seen = 0;
        forever begin
            @(posedge clk);
            ram_out_en <= 1'b0;
            if (ram_en === 1'b1) begin
                if (ram_wr_rd === 1'b1) begin
                    ram_mem[ram_addr] <= ram_wdata;
                    if (rstn === 1'b1) ram_wr_seen <= ram_wr_seen + 1;
                end else begin
                    ram_rdata  <= ram_mem[ram_addr];
                    ram_out_en <= !kill_out_en;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reset leaves address 0 written with zero (reset-time write); with the
    // INIT sweep every address is zero.
    task automatic model_reset();
        exp_wr = 0;
        exp_rd = 0;
        ref_mem[0] = '0;
`ifdef RAM_CMD_CTRL_INIT_EN
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
`endif
    endtask

    // Present a command and wait (bounded) until it is accepted. Returns the
    // number of cycles spent waiting for cmd_ready; on return the bench sits
    // in the cycle after the accept edge.
    task automatic send_cmd(input logic wr, input logic [AW-1:0] addr,
                            input logic [DW-1:0] data, output int waited,
                            output bit ok);
        cmd_valid = 1'b1;
        cmd_wr    = wr;
        cmd_addr  = addr;
        cmd_wdata = data;
        waited    = 0;
        ok        = 1'b0;
        for (int i = 0; i < 64; i++) begin
            if (cmd_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
            tick();
            waited++;
        end
        if (ok) tick();
        cmd_valid = 1'b0;
    endtask

    // Wait for a response (bounded), hold rsp_ready low for 'hold' cycles while
    // recording whether the response stayed stable, then complete the
    // handshake. lat counts cycles from the accept cycle to rsp_valid.
    task automatic recv_rsp(input int hold, output logic [DW-1:0] data,
                            output logic err, output int lat,
                            output bit stable, output bit got);
        lat    = 1;
        got    = 1'b0;
        stable = 1'b1;
        data   = '0;
        err    = 1'b0;
        for (int i = 0; i < 64; i++) begin
            if (rsp_valid === 1'b1) begin
                got = 1'b1;
                break;
            end
            tick();
            lat++;
        end
        if (got) begin
            data = rsp_data;
            err  = rsp_err;
            for (int h = 0; h < hold; h++) begin
                tick();
                if (rsp_valid !== 1'b1 || rsp_data !== data ||
                    rsp_err !== err || cmd_ready !== 1'b0) stable = 1'b0;
            end
            rsp_ready = 1'b1;
            tick();
            rsp_ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        int waited;
        rstn = 1'b0;
        repeat (3) tick();
        total++; if (ram_en !== 1'b1) begin bad++; $display("FAIL reset_ram_en: got %b want 1", ram_en); end
        total++; if (ram_wr_rd !== 1'b1 || ram_addr !== '0 || ram_wdata !== '0) begin bad++; $display("FAIL reset_ram_pins: got wr_rd=%b addr=%h data=%h want 1/0/0", ram_wr_rd, ram_addr, ram_wdata); end
        total++; if (cmd_ready !== 1'b0 || rsp_valid !== 1'b0 || rsp_err !== 1'b0 || rsp_data !== '0) begin bad++; $display("FAIL reset_handshake: got rdy=%b vld=%b err=%b data=%h want 0", cmd_ready, rsp_valid, rsp_err, rsp_data); end
        total++; if (wr_cnt !== 16'd0 || rd_cnt !== 16'd0) begin bad++; $display("FAIL reset_counters: got wr=%0d rd=%0d want 0", wr_cnt, rd_cnt); end
        rstn = 1'b1;
        model_reset();
        waited = 0;
        while (cmd_ready !== 1'b1 && waited < 64) begin
            tick();
            waited++;
        end
        total++; if (waited !== READY_WAIT) begin bad++; $display("FAIL reset_ready_delay: got %0d want %0d", waited, READY_WAIT); end
        total++; if (wr_cnt !== 16'd0) begin bad++; $display("FAIL reset_wr_cnt_after: got %0d want 0", wr_cnt); end
    endtask

    // Fill every address with back-to-back writes: one accept every 2 cycles.
    task automatic test_back_to_back();
        int waited;
        bit ok;
        logic [DW-1:0] d;
        for (int a = 0; a < DEPTH; a++) begin
            d = DW'($urandom);
            send_cmd(1'b1, AW'(a), d, waited, ok);
            ref_mem[a] = d;
            exp_wr++;
            total++; if (!ok) begin bad++; $display("FAIL b2b_accept[%0d]: got no accept want accept", a); end
            if (a > 0) begin
                total++; if (waited !== 1) begin bad++; $display("FAIL b2b_spacing[%0d]: got wait %0d want 1", a, waited); end
            end
        end
        tick();
        total++; if (wr_cnt !== 16'(exp_wr)) begin bad++; $display("FAIL b2b_wr_cnt: got %0d want %0d", wr_cnt, exp_wr); end
    endtask

    task automatic test_write_read();
        int waited, lat, seen0;
        bit ok, stable, got;
        logic [DW-1:0] d;
        logic e;
        seen0 = ram_wr_seen;
        send_cmd(1'b1, 4'd5, 8'hA5, waited, ok);
        ref_mem[5] = 8'hA5;
        exp_wr++;
        total++; if (ram_en !== 1'b1 || ram_wr_rd !== 1'b1 || ram_addr !== 4'd5 || ram_wdata !== 8'hA5) begin bad++; $display("FAIL wr_pins: got en=%b wr_rd=%b addr=%h data=%h want 1/1/5/a5", ram_en, ram_wr_rd, ram_addr, ram_wdata); end
        send_cmd(1'b0, 4'd5, 8'h00, waited, ok);
        total++; if (ram_wr_seen - seen0 !== 1) begin bad++; $display("FAIL wr_single_pulse: got %0d want 1", ram_wr_seen - seen0); end
        total++; if (ram_en !== 1'b1 || ram_wr_rd !== 1'b0 || ram_addr !== 4'd5) begin bad++; $display("FAIL rd_issue_pins: got en=%b wr_rd=%b addr=%h want 1/0/5", ram_en, ram_wr_rd, ram_addr); end
        recv_rsp(0, d, e, lat, stable, got);
        exp_rd++;
        total++; if (!got || lat !== 3) begin bad++; $display("FAIL rd_latency: got %0d want 3", lat); end
        total++; if (d !== 8'hA5 || e !== 1'b0) begin bad++; $display("FAIL rd_data: got %h err=%b want a5 err=0", d, e); end
        total++; if (wr_cnt !== 16'(exp_wr) || rd_cnt !== 16'(exp_rd)) begin bad++; $display("FAIL wr_rd_counts: got wr=%0d rd=%0d want %0d/%0d", wr_cnt, rd_cnt, exp_wr, exp_rd); end
    endtask

    task automatic test_backpressure();
        int waited, lat;
        bit ok, stable, got;
        logic [DW-1:0] d;
        logic e;
        send_cmd(1'b0, 4'd5, 8'h00, waited, ok);
        recv_rsp(4, d, e, lat, stable, got);
        exp_rd++;
        total++; if (!got || !stable) begin bad++; $display("FAIL bp_stable: got stable=%b want 1", stable); end
        total++; if (d !== ref_mem[5]) begin bad++; $display("FAIL bp_data: got %h want %h", d, ref_mem[5]); end
        total++; if (cmd_ready !== 1'b0 || rsp_valid !== 1'b0) begin bad++; $display("FAIL bp_gap: got rdy=%b vld=%b want 0/0", cmd_ready, rsp_valid); end
        tick();
        total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL bp_ready_after_gap: got %b want 1", cmd_ready); end
        total++; if (rd_cnt !== 16'(exp_rd)) begin bad++; $display("FAIL bp_rd_cnt: got %0d want %0d", rd_cnt, exp_rd); end
    endtask

    task automatic test_timeout();
        int waited, lat;
        bit ok, stable, got;
        logic [DW-1:0] d;
        logic e;
        kill_out_en = 1'b1;
        send_cmd(1'b0, AW'($urandom), 8'h00, waited, ok);
        recv_rsp(0, d, e, lat, stable, got);
        kill_out_en = 1'b0;
        exp_rd++;
        total++; if (!got || lat !== TO + 2) begin bad++; $display("FAIL to_latency: got %0d want %0d", lat, TO + 2); end
        total++; if (d !== '0 || e !== 1'b1) begin bad++; $display("FAIL to_resp: got data=%h err=%b want 00/1", d, e); end
        total++; if (rd_cnt !== 16'(exp_rd)) begin bad++; $display("FAIL to_rd_cnt: got %0d want %0d", rd_cnt, exp_rd); end
    endtask

    task automatic test_random();
        int waited, lat, hold;
        bit ok, stable, got, kill;
        logic [DW-1:0] d, wd;
        logic e;
        logic [AW-1:0] a;
        for (int n = 0; n < 40; n++) begin
            a  = AW'($urandom);
            wd = DW'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                send_cmd(1'b1, a, wd, waited, ok);
                ref_mem[a] = wd;
                exp_wr++;
                total++; if (!ok) begin bad++; $display("FAIL rnd_wr_accept[%0d]: got none want accept", n); end
            end else begin
                kill = ($urandom_range(0, 7) == 0);
                hold = $urandom_range(0, 3);
                kill_out_en = kill;
                send_cmd(1'b0, a, wd, waited, ok);
                recv_rsp(hold, d, e, lat, stable, got);
                kill_out_en = 1'b0;
                exp_rd++;
                total++;
                if (!got || d !== (kill ? '0 : ref_mem[a]) || e !== kill ||
                    lat !== (kill ? TO + 2 : 3) || !stable) begin
                    bad++;
                    $display("FAIL rnd_rd[%0d]: got data=%h err=%b lat=%0d stable=%b want data=%h err=%b lat=%0d stable=1",
                             n, d, e, lat, stable, kill ? 8'h00 : ref_mem[a], kill, kill ? TO + 2 : 3);
                end
            end
        end
        tick();
        total++; if (wr_cnt !== 16'(exp_wr) || rd_cnt !== 16'(exp_rd)) begin bad++; $display("FAIL rnd_counts: got wr=%0d rd=%0d want %0d/%0d", wr_cnt, rd_cnt, exp_wr, exp_rd); end
    endtask

    task automatic test_reset_midop();
        int waited, first;
        bit ok, seen;
        kill_out_en = 1'b1;
        send_cmd(1'b0, 4'd3, 8'h00, waited, ok);
        repeat (3) tick();
        rstn = 1'b0;
        repeat (2) tick();
        total++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b0 || ram_en !== 1'b1) begin bad++; $display("FAIL midrst_outputs: got vld=%b rdy=%b en=%b want 0/0/1", rsp_valid, cmd_ready, ram_en); end
        total++; if (wr_cnt !== 16'd0 || rd_cnt !== 16'd0) begin bad++; $display("FAIL midrst_counters: got wr=%0d rd=%0d want 0", wr_cnt, rd_cnt); end
        rstn = 1'b1;
        kill_out_en = 1'b0;
        model_reset();
        seen  = 1'b0;
        first = -1;
        for (int i = 0; i < DEPTH + TO + 8; i++) begin
            tick();
            if (rsp_valid === 1'b1) seen = 1'b1;
            if (cmd_ready === 1'b1 && first < 0) first = i + 1;
        end
        total++; if (seen !== 1'b0) begin bad++; $display("FAIL midrst_no_rsp: got rsp_valid seen want never"); end
        total++; if (first !== READY_WAIT) begin bad++; $display("FAIL midrst_ready: got %0d want %0d", first, READY_WAIT); end
    endtask

    // Reads right after a reset: address 15 keeps its old value in the
    // default build and is zero after the INIT sweep; address 0 is zero.
    task automatic test_read_after_reset();
        int waited, lat;
        bit ok, stable, got;
        logic [DW-1:0] d;
        logic e;
        send_cmd(1'b0, 4'd15, 8'h00, waited, ok);
        recv_rsp(0, d, e, lat, stable, got);
        exp_rd++;
        total++; if (!got || d !== ref_mem[15] || e !== 1'b0) begin bad++; $display("FAIL post_rst_rd15: got %h err=%b want %h err=0", d, e, ref_mem[15]); end
        send_cmd(1'b0, 4'd0, 8'h00, waited, ok);
        recv_rsp(1, d, e, lat, stable, got);
        exp_rd++;
        total++; if (!got || d !== 8'h00) begin bad++; $display("FAIL post_rst_rd0: got %h want 00", d); end
        total++; if (rd_cnt !== 16'(exp_rd) || wr_cnt !== 16'd0) begin bad++; $display("FAIL post_rst_counts: got wr=%0d rd=%0d want 0/%0d", wr_cnt, rd_cnt, exp_rd); end
    endtask

    initial begin
        exp_wr = 0;
        exp_rd = 0;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
        test_reset();
        test_back_to_back();
        test_write_read();
        test_backpressure();
        test_timeout();
        test_random();
        test_reset_midop();
        test_read_after_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog expired");
    end

endmodule
